// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the KGP-RISC fetch/issue front end: instruction field
// positions and the fetch controller state encoding.
package kgp_risc_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int EXT_HI  = 10;
  localparam int EXT_LO  = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_issue_fifo.sv
// Prefetch queue holding {pc, instr} entries; flush wins over push and pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_doPush;
  logic             w_doPop;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_rdata  = r_mem[r_rdPtr];
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_doPush = i_push && !i_flush && (!w_full || i_pop);
  assign w_doPop  = i_pop && !i_flush && !o_empty;

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_doPush && w_doPop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch_issue.sv
// KGP-RISC fetch/issue front end: sequential fetch with one outstanding request,
// prefetch queue, valid/ready issue to decode and branch redirect with squash.
module instr_fetch_issue
  import kgp_risc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [5:0]         opcode,
  output logic [10:0]        opcode_ext,
  output logic [INSTR_W-1:0] issue_instr,
  output logic [ADDR_W-1:0]  issue_pc,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target
);

  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam int CNT_W   = $clog2(DEPTH+1);

  fetch_state_e       r_state;
  fetch_state_e       w_nextState;
  logic [ADDR_W-1:0]  r_fetchPc;
  logic [ADDR_W-1:0]  w_nextPc;
  logic [ADDR_W-1:0]  w_target;
  logic [CNT_W-1:0]   w_count;
  logic               w_empty;
  logic               w_canReq;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic [INSTR_W-1:0] w_headInstr;
  logic [ADDR_W-1:0]  w_headPc;

  assign w_target = branch_target & ~ADDR_W'(3);
  // Gating with rst keeps the request strobe low while reset is held.
  assign w_canReq = rst && run && (w_count < CNT_W'(DEPTH));
  assign w_pop    = !w_empty && issue_ready && !branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_fetchPc <= RESET_PC;
    end else begin
      r_state   <= w_nextState;
      r_fetchPc <= w_nextPc;
    end
  end

  // A redirect overrides everything: no new request, the returning word is dropped,
  // and a request still in flight is marked for discard via S_DROP.
  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_fetchPc;
    w_push      = 1'b0;
    imem_req    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!branch_taken && w_canReq) begin
          imem_req    = 1'b1;
          w_nextState = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_nextState = S_IDLE;
          if (!branch_taken) begin
            w_push   = 1'b1;
            w_nextPc = r_fetchPc + ADDR_W'(4);
          end
        end else if (branch_taken) begin
          w_nextState = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
    if (branch_taken) w_nextPc = w_target;
  end

  assign imem_addr = imem_req ? r_fetchPc : '0;

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (branch_taken),
    .i_wdata ({r_fetchPc, imem_rdata}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign w_headInstr = w_head[INSTR_W-1:0];
  assign w_headPc    = w_head[ENTRY_W-1 -: ADDR_W];

  // Head fields are forced to zero whenever the queue is empty so reset and idle look alike.
  assign issue_valid = !w_empty;
  assign issue_instr = w_empty ? '0 : w_headInstr;
  assign issue_pc    = w_empty ? '0 : w_headPc;
  assign opcode      = w_empty ? '0 : w_headInstr[OPC_HI:OPC_LO];
  assign opcode_ext  = w_empty ? '0 : w_headInstr[EXT_HI:EXT_LO];

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench for instr_fetch_issue: directed scenarios then random traffic,
// checked every cycle against a program-order model of fetch and issue.
module tb_instr_fetch_issue;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  logic        clk;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  opcode;
  logic [10:0] opcode_ext;
  logic [31:0] issue_instr;
  logic [31:0] issue_pc;
  logic        branch_taken;
  logic [31:0] branch_target;

  int compared   = 0;
  int mismatched = 0;

  // Model: instructions since the last redirect form a sequence starting at epochPc.
  logic [31:0] epochPc;
  int          accepted;
  int          issued;
  int          totalIssued;
  bit          outstanding;
  bit          stale;

  bit          pendActive;
  logic [31:0] pendAddr;
  int          pendLeft;
  int          latency;
  bit          randLat;
  bit          strayEn;
  bit          forceStray;
  bit          lastRvalid;

  logic [31:0] reqLog[$];
  logic [31:0] issuePcLog[$];
  bit          sValid;
  logic [5:0]  sOpc;
  logic [10:0] sExt;
  logic [31:0] sPc;
  bit          haveFirst;
  logic [5:0]  firstOpc;
  logic [31:0] firstPc;
  bit          found;

  instr_fetch_issue #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .opcode       (opcode),
    .opcode_ext   (opcode_ext),
    .issue_instr  (issue_instr),
    .issue_pc     (issue_pc),
    .branch_taken (branch_taken),
    .branch_target(branch_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0)   return 32'h0C00_0000;
    if (a == 32'h100) return 32'h0000_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] qAt(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    epochPc     = 32'h0;
    accepted    = 0;
    issued      = 0;
    outstanding = 1'b0;
    stale       = 1'b0;
    pendActive  = 1'b0;
    haveFirst   = 1'b0;
    reqLog.delete();
    issuePcLog.delete();
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst          = 1'b0;
    run          = 1'b1;
    imem_rvalid  = 1'b0;
    branch_taken = 1'b0;
    #1;
    checkOutput("rst_imem_req",    32'(imem_req),    32'h0);
    checkOutput("rst_imem_addr",   imem_addr,        32'h0);
    checkOutput("rst_issue_valid", 32'(issue_valid), 32'h0);
    checkOutput("rst_opcode",      32'(opcode),      32'h0);
    checkOutput("rst_opcode_ext",  32'(opcode_ext),  32'h0);
    checkOutput("rst_issue_instr", issue_instr,      32'h0);
    checkOutput("rst_issue_pc",    issue_pc,         32'h0);
    modelReset();
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic applyStimulus(input bit runV, input bit readyV, input bit brV, input logic [31:0] tgt);
    bit          expValid;
    bit          expReq;
    bit          respond;
    logic [31:0] expAddr;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    @(posedge clk);
    #1;
    run           = runV;
    issue_ready   = readyV;
    branch_taken  = brV;
    branch_target = tgt;
    imem_rvalid   = 1'b0;
    imem_rdata    = $urandom;
    if (pendActive) begin
      pendLeft--;
      if (pendLeft == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memWord(pendAddr);
        pendActive  = 1'b0;
      end
    end else if (forceStray || (strayEn && $urandom_range(0, 7) == 0)) begin
      imem_rvalid = 1'b1;
    end
    lastRvalid = imem_rvalid;
    @(negedge clk);

    expValid = (accepted != issued);
    expReq   = !outstanding && runV && ((accepted - issued) < DEPTH) && !brV;
    expAddr  = expReq ? epochPc + 32'(accepted) * 4 : 32'h0;
    expPc    = expValid ? epochPc + 32'(issued) * 4 : 32'h0;
    expInstr = expValid ? memWord(expPc) : 32'h0;
    checkOutput("imem_req",    32'(imem_req),    32'(expReq));
    checkOutput("imem_addr",   imem_addr,        expAddr);
    checkOutput("issue_valid", 32'(issue_valid), 32'(expValid));
    checkOutput("issue_pc",    issue_pc,         expPc);
    checkOutput("issue_instr", issue_instr,      expInstr);
    checkOutput("opcode",      32'(opcode),      32'(expInstr[31:26]));
    checkOutput("opcode_ext",  32'(opcode_ext),  32'(expInstr[10:0]));

    sValid = issue_valid;
    sOpc   = opcode;
    sExt   = opcode_ext;
    sPc    = issue_pc;
    if (issue_valid && !haveFirst) begin
      haveFirst = 1'b1;
      firstOpc  = opcode;
      firstPc   = issue_pc;
    end
    if (imem_req) reqLog.push_back(imem_addr);
    if (issue_valid && readyV && !brV) issuePcLog.push_back(issue_pc);
    if (imem_req) begin
      pendActive = 1'b1;
      pendAddr   = imem_addr;
      pendLeft   = randLat ? int'($urandom_range(1, 4)) : latency;
    end

    respond = lastRvalid && outstanding;
    if (brV) begin
      epochPc  = tgt & ~32'h3;
      accepted = 0;
      issued   = 0;
      if (respond) outstanding = 1'b0;
      stale = outstanding;
    end else begin
      if (expValid && readyV) begin
        issued++;
        totalIssued++;
      end
      if (respond) begin
        if (!stale) accepted++;
        outstanding = 1'b0;
        stale       = 1'b0;
      end
      if (expReq) begin
        outstanding = 1'b1;
        stale       = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; issue_ready = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    latency = 1; randLat = 1'b0; strayEn = 1'b0; forceStray = 1'b0;
    totalIssued = 0; found = 1'b0;
    modelReset();

    $display("[TB] sequential fetch, latency 1");
    doReset();
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("A_req0",     qAt(reqLog, 0), 32'h0);
    checkOutput("A_req1",     qAt(reqLog, 1), 32'h4);
    checkOutput("A_req2",     qAt(reqLog, 2), 32'h8);
    checkOutput("A_firstOpc", 32'(firstOpc),  32'h3);
    checkOutput("A_firstPc",  firstPc,        32'h0);

    $display("[TB] queue fills while decode stalls");
    doReset();
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("B_reqCount", 32'(reqLog.size()), 32'd4);
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("B_iss0", qAt(issuePcLog, 0), 32'h0);
    checkOutput("B_iss1", qAt(issuePcLog, 1), 32'h4);
    checkOutput("B_iss2", qAt(issuePcLog, 2), 32'h8);
    checkOutput("B_iss3", qAt(issuePcLog, 3), 32'hC);
    checkOutput("B_req4", qAt(reqLog, 4),     32'h10);

    $display("[TB] redirect with a request in flight, latency 3");
    doReset();
    latency = 3;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      if (reqLog.size() > 0 && reqLog[$] == 32'h8) found = 1'b1;
    end
    checkOutput("C_sawReq8", 32'(found), 32'h1);
    reqLog.delete();
    issuePcLog.delete();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("C_req0", qAt(reqLog, 0),     32'h40);
    checkOutput("C_iss0", qAt(issuePcLog, 0), 32'h40);

    $display("[TB] redirect coinciding with a response");
    latency = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      if (pendActive && pendLeft == 1) found = 1'b1;
    end
    checkOutput("D_armed", 32'(found), 32'h1);
    reqLog.delete();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
    checkOutput("D_rvalidSameCycle", 32'(lastRvalid), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("D_reqCount", 32'(reqLog.size()), 32'd1);
    checkOutput("D_req0",     qAt(reqLog, 0),     32'h80);

    $display("[TB] reset while waiting with queued entries");
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      if ((accepted - issued) == 2 && outstanding) found = 1'b1;
    end
    checkOutput("E_twoQueued", 32'(found), 32'h1);
    doReset();
    forceStray = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    forceStray = 1'b0;
    checkOutput("E_strayDriven", 32'(lastRvalid), 32'h1);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("E_req0", qAt(reqLog, 0), 32'h0);

    $display("[TB] opcode_ext field extraction");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      if (sValid) found = 1'b1;
    end
    checkOutput("F_valid",  32'(found), 32'h1);
    checkOutput("F_opcode", 32'(sOpc),  32'h0);
    checkOutput("F_ext",    32'(sExt),  32'h4);
    checkOutput("F_pc",     sPc,        32'h100);

    $display("[TB] random traffic");
    randLat = 1'b1;
    strayEn = 1'b1;
    totalIssued = 0;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 25) == 0, $urandom);
    end
    checkOutput("G_progress", 32'(totalIssued > 200), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch_issue.md
Name: instr_fetch_issue

Overview:
Instruction fetch and issue front end for the KGP-RISC core. It generates PC-sequential fetches to instruction memory and buffers returned words in a small prefetch queue. It issues each instruction to the ControlUnit as opcode/opcode_ext fields with a valid/ready handshake. It redirects on taken branches, squashing queued and in-flight fetches.

Parameters:
ADDR_W, 32, PC / instruction-memory byte-address width
DEPTH, 4, prefetch queue entries (power of 2, >=2)
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
run  in  1  level; 1 = fetch enabled, 0 = stop issuing new memory requests
imem_req  out  1  memory request strobe, one cycle per request
imem_addr  out  ADDR_W  request byte address
imem_rvalid  in  1  response valid
imem_rdata  in  32  response instruction word
issue_valid  out  1  head instruction available to decode
issue_ready  in  1  decode accepts head this cycle
opcode  out  6  instr[31:26] of head
opcode_ext  out  11  instr[10:0] of head
issue_instr  out  32  full head word
issue_pc  out  ADDR_W  PC of head
branch_taken  in  1  redirect strobe from execute
branch_target  in  ADDR_W  redirect PC (bits [1:0] forced to 0)

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; queue empty; FSM=S_IDLE.
  - All outputs 0: imem_req, imem_addr, issue_valid, opcode, opcode_ext, issue_instr, issue_pc.
  - Reset mid-request: response arriving after reset release with no request issued since is ignored (covered by S_IDLE ignoring rvalid).
- At most one outstanding memory request; response latency >=1 cycle, unbounded.
- FSM:
  - S_IDLE: if run && (count < DEPTH), assert imem_req, imem_addr=fetch_pc, go S_WAIT. imem_rvalid is ignored here.
  - S_WAIT: on imem_rvalid, push {fetch_pc, rdata}, fetch_pc += 4, go S_IDLE. A push may issue the next request in the same cycle only from S_IDLE, so peak throughput is 1 instruction per 2 cycles.
  - S_DROP: on imem_rvalid, discard the word and go S_IDLE.
- Redirect (branch_taken=1), highest priority:
  - Queue is flushed; issue_valid=0 next cycle.
  - fetch_pc=branch_target.
  - From S_WAIT without same-cycle rvalid: go S_DROP.
  - From S_WAIT with same-cycle rvalid: discard the word, go S_IDLE.
  - From S_IDLE: no request is issued that cycle; stay S_IDLE.
  - From S_DROP: stay S_DROP, unless rvalid arrives the same cycle, then go S_IDLE.
- Issue:
  - issue_valid = queue non-empty; outputs are registered from the head entry.
  - Pop when issue_valid && issue_ready && !branch_taken.
  - A pop and a push in the same cycle are allowed, and count is unchanged.
  - Full (count==DEPTH): no new request. A full queue with a pop frees a slot the next cycle.
  - issue_* fields are held stable while issue_valid && !issue_ready.
- run=0:
  - No new requests; an outstanding request still completes and pushes.
  - Issue continues draining the queue.
- Arithmetic: fetch_pc wraps modulo 2^ADDR_W. count is width $clog2(DEPTH+1). Queue pointers are log2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package (kgp_risc_pkg):
  - opcode field positions OPC_HI=31, OPC_LO=26, EXT_HI=10, EXT_LO=0.
  - INSTR_W=32.
  - FSM state encoding S_IDLE, S_WAIT, S_DROP.
- Sub-module fetch_fifo: synchronous FIFO of {pc, instr}.
  - Controls: push, pop, flush.
  - Status: count, full, empty.
  - Flush has priority over push and pop.

Test Plan:
- Reset release, run=1, memory latency 1, issue_ready=1, RESET_PC=0, mem[0]=0x0C000000 -> imem_addr sequence 0, 4, 8; first issue_valid shows opcode=3, issue_pc=0.
- issue_ready=0, run=1 -> exactly 4 requests; queue full; imem_req stays 0. Raise issue_ready -> 4 in-order issues, PCs 0, 4, 8, 12, then fetching resumes at 16.
- Latency 3; branch_taken with target 0x40 on the cycle after the request to 0x8 -> the late word for 0x8 is never issued; next imem_addr=0x40; first issued issue_pc=0x40.
- branch_taken with target 0x80 in the same cycle as imem_rvalid -> the word is discarded; the FSM issues a request to 0x80 on the following cycle.
- rst asserted while in S_WAIT with 2 queued entries -> all outputs 0 immediately. After release, the next request goes to RESET_PC and a stray rvalid is ignored.
- opcode_ext check: fetched word 0x00000004 -> opcode=0, opcode_ext=4 presented on the same cycle as issue_valid.
